// File: rtl/mem_if_burst_writer.sv
// Header-prefixed AXI-Stream packets to AXI3 write bursts, split on MAX_BURST and 4 KB.
// Optional MEM_IF_WR_LAST_CHECK_EN: flag tlast disagreeing with the header length.
module mem_if_burst_writer #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 6,
    parameter int BLEN_WIDTH      = 4,
    parameter int MAX_BURST       = 16,
    parameter int BEAT_ADDR_WIDTH = 20,
    parameter int BUF_IDX_WIDTH   = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 512,
    parameter int CFG_WIDTH       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_axis_tdata,
    input  logic                    rx_axis_tlast,
    input  logic                    rx_axis_tvalid,
    output logic                    rx_axis_tready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [BLEN_WIDTH-1:0]   m_axi_awlen,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ID_WIDTH-1:0]     m_axi_wid,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [CFG_WIDTH-1:0]    ddr_addr_offset_in,
    output logic                    idle_out,
    output logic                    err_out,
    output logic [CFG_WIDTH-1:0]    err_count_out
);
    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BAW   = BEAT_ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_AW, S_DATA, S_NEXT} state_t;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count, count_nxt;
    logic                  push, pop, empty;
    logic [DATA_WIDTH-1:0] head;
    logic                  head_last;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr, hdr_addr;
    logic [BAW-1:0]        remaining, burst, next_burst, bnd_beats, hdr_len;
    logic [12:0]           bnd_bytes;
    logic [BLEN_WIDTH-1:0] beat_cnt;
    logic [OUT_W-1:0]      outstanding;
    logic                  aw_hs, w_hs, b_err, last_err;
    logic [CFG_WIDTH:0]    err_sum;

    assign push  = rx_axis_tvalid & rx_axis_tready;
    assign empty = (count == '0);
    assign {head_last, head} = mem[rd_ptr];
    assign pop   = (state == S_HDR) | w_hs;

    always_comb begin
        count_nxt = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {rx_axis_tlast, rx_axis_tdata};
    end

    // tready looks at next-cycle occupancy, so one spare slot covers the registered lag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rx_axis_tready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count          <= count_nxt;
            rx_axis_tready <= count_nxt < (PTR_W+1)'(FIFO_DEPTH - 1);
        end
    end

    assign hdr_len  = head[0 +: BAW];
    assign hdr_addr = (ADDR_WIDTH'({head[2*BAW +: BUF_IDX_WIDTH], head[BAW +: BAW]}) << SHIFT)
                    + ADDR_WIDTH'(ddr_addr_offset_in);

    always_comb begin
        bnd_bytes  = 13'h1000 - {1'b0, cur_addr[11:0]};
        bnd_beats  = BAW'(bnd_bytes >> SHIFT);
        next_burst = remaining;
        if (next_burst > BAW'(MAX_BURST)) next_burst = BAW'(MAX_BURST);
        if (next_burst > bnd_beats)       next_burst = bnd_beats;
    end

    assign m_axi_awid   = '0;
    assign m_axi_wid    = '0;
    assign m_axi_wstrb  = '1;
    assign m_axi_bready = 1'b1;
    assign m_axi_wdata  = head;
    assign m_axi_wvalid = (state == S_DATA) & ~empty;
    assign m_axi_wlast  = (state == S_DATA) & (beat_cnt == m_axi_awlen);
    assign aw_hs        = m_axi_awvalid & m_axi_awready;
    assign w_hs         = m_axi_wvalid & m_axi_wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            cur_addr      <= '0;
            remaining     <= '0;
            burst         <= '0;
            beat_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: if (!empty) state <= S_HDR;
                S_HDR: begin
                    cur_addr  <= hdr_addr;
                    remaining <= hdr_len;
                    state     <= (hdr_len == '0) ? S_IDLE : S_AW;
                end
                S_AW: begin
                    if (m_axi_awvalid) begin
                        if (m_axi_awready) begin
                            m_axi_awvalid <= 1'b0;
                            beat_cnt      <= '0;
                            state         <= S_DATA;
                        end
                    end else if (outstanding < OUT_W'(MAX_OUTSTANDING)) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= cur_addr;
                        m_axi_awlen   <= BLEN_WIDTH'(next_burst - 1'b1);
                        burst         <= next_burst;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (m_axi_wlast) state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    cur_addr  <= cur_addr + (ADDR_WIDTH'(burst) << SHIFT);
                    remaining <= remaining - burst;
                    state     <= (remaining == burst) ? S_IDLE : S_AW;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign b_err = m_axi_bvalid & (m_axi_bresp != 2'b00);
`ifdef MEM_IF_WR_LAST_CHECK_EN
    assign last_err = w_hs & (head_last != (m_axi_wlast & (remaining == burst)));
`else
    assign last_err = 1'b0;
`endif
    assign err_sum = {1'b0, err_count_out}
                   + (CFG_WIDTH+1)'(b_err) + (CFG_WIDTH+1)'(last_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding   <= '0;
            err_out       <= 1'b0;
            err_count_out <= '0;
            idle_out      <= 1'b0;
        end else begin
            case ({aw_hs, m_axi_bvalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            if (b_err | last_err) begin
                err_out       <= 1'b1;
                err_count_out <= err_sum[CFG_WIDTH] ? '1 : err_sum[CFG_WIDTH-1:0];
            end
            idle_out <= (state == S_IDLE) & empty & (outstanding == '0);
        end
    end

    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, head_last};
endmodule

// File: tb/tb_mem_if_burst_writer.sv
// Randomised bench for mem_if_burst_writer against a packet/burst-level reference model.
module tb_mem_if_burst_writer;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] tdata = '0;
    logic        tlast = 1'b0, tvalid = 1'b0, tready;
    logic [5:0]  awid, wid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] cfg_off = '0;
    logic        idle_out, err_out;
    logic [31:0] err_count;

    always #5 clk = ~clk;

    mem_if_burst_writer dut (
        .clk(clk), .reset(reset),
        .rx_axis_tdata(tdata), .rx_axis_tlast(tlast),
        .rx_axis_tvalid(tvalid), .rx_axis_tready(tready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wid(wid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(6'd0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .ddr_addr_offset_in(cfg_off),
        .idle_out(idle_out), .err_out(err_out), .err_count_out(err_count)
    );

    int checks = 0, errors = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] q_aw_addr[$];
    logic [3:0]  q_aw_len[$];
    logic [63:0] q_wd[$];
    logic        q_wl[$];
    int  aw_done = 0, b_done = 0, w_bursts = 0, err_exp = 0;
    int  err_req = 0, err_ack = 0;
    bit  viol_out = 0, viol_w = 0;
    bit  b_en = 1, w_en = 1, rnd_rdy = 0, rnd_berr = 0, gap_en = 0;

    // AXI slave model; all decisions at negedge predict the following posedge
    always @(negedge clk) begin
        if (reset) begin
            bvalid = 0; bresp = 0; awready = 0; wready = 0;
        end else begin
            if (awvalid && (aw_done - b_done) >= MAXO) viol_out = 1;
            bvalid = 0; bresp = 0;
            if (b_en && aw_done > b_done && (!rnd_rdy || $urandom_range(1, 0) == 1)) begin
                bvalid = 1;
                if (err_req != err_ack) begin
                    bresp = 2'b10; err_ack = err_req;
                end else if (rnd_berr && $urandom_range(7, 0) == 0)
                    bresp = 2'b11;
                if (bresp != 2'b00) err_exp++;
                b_done++;
            end
            awready = !rnd_rdy || $urandom_range(3, 0) != 0;
            wready  = w_en && (!rnd_rdy || $urandom_range(3, 0) != 0);
            if (awvalid && awready) begin
                check_eq("aw_expected", 64'(q_aw_addr.size() != 0), 1);
                if (q_aw_addr.size() != 0) begin
                    check_eq("awaddr", awaddr, q_aw_addr.pop_front());
                    check_eq("awlen", awlen, q_aw_len.pop_front());
                end
                aw_done++;
            end
            if (wvalid && wready) begin
                if (aw_done <= w_bursts) viol_w = 1;
                check_eq("w_expected", 64'(q_wd.size() != 0), 1);
                if (q_wd.size() != 0) begin
                    check_eq("wdata", wdata, q_wd.pop_front());
                    check_eq("wlast", wlast, q_wl.pop_front());
                end
                check_eq("wstrb", wstrb, 8'hFF);
                if (wlast) w_bursts++;
            end
        end
    end

    task automatic send_beat(logic [63:0] d, logic l);
        int n = 0;
        @(negedge clk);
        tvalid = 0;
        if (gap_en) while ($urandom_range(3, 0) == 0) @(negedge clk);
        tdata = d; tlast = l; tvalid = 1;
        while (!tready && n < 20000) begin @(negedge clk); n++; end
        if (!tready) check_eq("tready_timeout", tready, 1);
        @(posedge clk);
    endtask

    // Reference: byte address from header fields, then split by 16 beats and 4 KB
    task automatic send_pkt(int len, logic [19:0] ba, logic [3:0] bi);
        logic [63:0] dat[$];
        logic [31:0] a;
        int rem, b, bnd, k;
        for (int i = 0; i < len; i++) dat.push_back({$urandom, $urandom});
        a = ((32'(bi) * 32'h10_0000) + 32'(ba)) * 8 + cfg_off;
        rem = len; k = 0;
        while (rem > 0) begin
            bnd = (4096 - int'(a % 4096)) / 8;
            b = rem;
            if (b > 16) b = 16;
            if (b > bnd) b = bnd;
            q_aw_addr.push_back(a);
            q_aw_len.push_back(4'(b - 1));
            for (int j = 0; j < b; j++) begin
                q_wd.push_back(dat[k]); q_wl.push_back(j == b - 1); k++;
            end
            a += 32'(b * 8);
            rem -= b;
        end
        send_beat(64'(len) | (64'(ba) << 20) | (64'(bi) << 40), 1'b0);
        for (int i = 0; i < len; i++) send_beat(dat[i], i == len - 1);
        @(negedge clk);
        tvalid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_aw_addr.size() != 0 || q_wd.size() != 0 || aw_done != b_done)
               && n < 20000) begin
            @(negedge clk); n++;
        end
        check_eq("drain_done", 64'(n < 20000), 1);
        repeat (3) @(negedge clk);
        check_eq("idle", idle_out, 1);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_tready", tready, 0);
        check_eq("rst_awaddr", awaddr, 0);
        check_eq("rst_awlen", awlen, 0);
        check_eq("rst_err", err_out, 0);
        check_eq("rst_errcnt", err_count, 0);
        reset = 0;
        @(negedge clk);
        check_eq("tready_up", tready, 1);
        check_eq("idle_up", idle_out, 1);
        check_eq("bready", bready, 1);

        cfg_off = 32'h1000_0000;
        base = aw_done;
        send_pkt(16, 20'd0, 4'd0);
        drain();
        check_eq("s1_aw_count", aw_done - base, 1);

        base = aw_done;
        send_pkt(40, 20'd0, 4'd0);
        drain();
        check_eq("s2_aw_count", aw_done - base, 3);

        cfg_off = 32'h0;
        base = aw_done;
        send_pkt(8, 20'd508, 4'd0);
        drain();
        check_eq("s3_aw_count", aw_done - base, 2);

        b_en = 0;
        base = aw_done;
        send_pkt(96, 20'd0, 4'd0);
        repeat (100) @(negedge clk);
        check_eq("s4_aw_stall", aw_done - base, 4);
        check_eq("s4_awvalid_low", awvalid, 0);
        b_en = 1;
        drain();
        check_eq("s4_aw_count", aw_done - base, 6);

        err_req++;
        send_pkt(16, 20'd3, 4'd1);
        drain();
        check_eq("s5_err", err_out, 1);
        check_eq("s5_errcnt", err_count, 1);
        base = aw_done;
        send_pkt(0, 20'd77, 4'd2);
        send_pkt(8, 20'd16, 4'd2);
        drain();
        check_eq("s5_len0_aw", aw_done - base, 1);
        check_eq("s5_errcnt_hold", err_count, 1);

        w_en = 0;
        fork
            send_pkt(600, 20'd40, 4'd3);
            begin
                int n = 0;
                while (tready && n < 5000) begin @(negedge clk); n++; end
                check_eq("s6_tready_drop", tready, 0);
                repeat (50) @(negedge clk);
                check_eq("s6_tready_held", tready, 0);
                w_en = 1;
            end
        join
        drain();

        rnd_rdy = 1; rnd_berr = 1; gap_en = 1;
        for (int g = 0; g < 4; g++) begin
            cfg_off = $urandom & 32'hFFFF_F000;
            for (int p = 0; p < 5; p++) begin
                logic [19:0] ba;
                ba = 20'($urandom);
                if ($urandom_range(1, 0) == 1) ba[8:0] = 9'($urandom_range(511, 496));
                send_pkt($urandom_range(60, 0), ba, 4'($urandom));
            end
            drain();
        end

        check_eq("outstanding_limit", viol_out, 0);
        check_eq("w_after_aw", viol_w, 0);
        check_eq("err_count", err_count, err_exp);
        check_eq("err_flag", err_out, err_exp != 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
